// File: rtl/dec_req_scheduler.sv
// Two-requester round-robin scheduler for the shared decoder: grants one codeword at a time,
// pulses the decoder enable for a cycle, returns the tagged result and keeps error statistics.
module dec_req_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [DATA_WIDTH-1:0] i_req0_codeword,
  input  logic [1:0]            i_req0_width,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [DATA_WIDTH-1:0] i_req1_codeword,
  input  logic [1:0]            i_req1_width,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic                  o_resp_id,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic [1:0]            o_resp_num_of_errors,
  output logic [DATA_WIDTH-1:0] o_dec_codeword,
  output logic [1:0]            o_dec_codeword_width,
  output logic                  o_dec_enable,
  input  logic [1:0]            i_dec_num_of_errors,
  input  logic [DATA_WIDTH-1:0] i_dec_data_out,
  input  logic                  i_clr_counters,
  output logic [CNT_WIDTH-1:0]  o_corr_count,
  output logic [CNT_WIDTH-1:0]  o_uncorr_count,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_lastGrant;
  logic [DATA_WIDTH-1:0] r_decCodeword;
  logic [1:0]            r_decWidth;
  logic                  r_decEnable;
  logic                  r_respValid;
  logic                  r_respId;
  logic [DATA_WIDTH-1:0] r_respData;
  logic [1:0]            r_respErrors;
  logic [CNT_WIDTH-1:0]  r_corrCount;
  logic [CNT_WIDTH-1:0]  r_uncorrCount;
  logic                  r_busy;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_sel;
  logic w_corrInc;
  logic w_uncorrInc;

  // On contention the requester that did not win last time gets the grant.
  assign w_idle      = (r_state == IDLE);
  assign w_grant0    = i_req0_valid & (~i_req1_valid | r_lastGrant);
  assign w_grant1    = i_req1_valid & (~i_req0_valid | ~r_lastGrant);
  assign o_req0_ready = w_idle & w_grant0;
  assign o_req1_ready = w_idle & w_grant1;
  assign w_accept    = o_req0_ready | o_req1_ready;
  assign w_sel       = o_req1_ready;

  assign w_corrInc   = (r_state == DECODE) && (i_dec_num_of_errors == 2'd1) && !(&r_corrCount);
  assign w_uncorrInc = (r_state == DECODE) && (i_dec_num_of_errors == 2'd2) && !(&r_uncorrCount);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_lastGrant   <= 1'b1;
      r_decCodeword <= '0;
      r_decWidth    <= 2'b00;
      r_decEnable   <= 1'b0;
      r_respValid   <= 1'b0;
      r_respId      <= 1'b0;
      r_respData    <= '0;
      r_respErrors  <= 2'b00;
      r_corrCount   <= '0;
      r_uncorrCount <= '0;
      r_busy        <= 1'b0;
    end else begin
      // A clear request wins over an increment landing on the same edge.
      if (i_clr_counters) begin
        r_corrCount   <= '0;
        r_uncorrCount <= '0;
      end else begin
        if (w_corrInc)   r_corrCount   <= r_corrCount + 1'b1;
        if (w_uncorrInc) r_uncorrCount <= r_uncorrCount + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_decCodeword <= w_sel ? i_req1_codeword : i_req0_codeword;
            r_decWidth    <= w_sel ? i_req1_width : i_req0_width;
            r_respId      <= w_sel;
            r_lastGrant   <= w_sel;
            r_decEnable   <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= DECODE;
          end
        end
        DECODE: begin
          r_respData   <= i_dec_data_out;
          r_respErrors <= i_dec_num_of_errors;
          r_decEnable  <= 1'b0;
          r_respValid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (i_resp_ready) begin
            r_respValid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_decEnable <= 1'b0;
          r_respValid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_dec_codeword       = r_decCodeword;
  assign o_dec_codeword_width = r_decWidth;
  assign o_dec_enable         = r_decEnable;
  assign o_resp_valid         = r_respValid;
  assign o_resp_id            = r_respId;
  assign o_resp_data          = r_respData;
  assign o_resp_num_of_errors = r_respErrors;
  assign o_corr_count         = r_corrCount;
  assign o_uncorr_count       = r_uncorrCount;
  assign o_busy               = r_busy;

endmodule

// File: tb/tb_dec_req_scheduler.sv
// Directed bench for dec_req_scheduler with a behavioural decoder stub and a response scoreboard;
// a second instance with 2-bit counters shares the stimulus to exercise counter saturation.
module tb_dec_req_scheduler;

  localparam int DW = 32;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic [1:0]    err;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          req0Valid;
  logic          req0Ready;
  logic [DW-1:0] req0Cw;
  logic [1:0]    req0Width;
  logic          req1Valid;
  logic          req1Ready;
  logic [DW-1:0] req1Cw;
  logic [1:0]    req1Width;
  logic          respValid;
  logic          respReady;
  logic          respId;
  logic [DW-1:0] respData;
  logic [1:0]    respErr;
  logic [DW-1:0] decCodeword;
  logic [1:0]    decWidth;
  logic          decEnable;
  logic [1:0]    decErr;
  logic [DW-1:0] decDataOut;
  logic          clrCounters;
  logic [15:0]   corrCount;
  logic [15:0]   uncorrCount;
  logic          busy;

  logic          smallReq0Ready;
  logic          smallReq1Ready;
  logic          smallRespValid;
  logic          smallRespId;
  logic [DW-1:0] smallRespData;
  logic [1:0]    smallRespErr;
  logic [DW-1:0] smallDecCodeword;
  logic [1:0]    smallDecWidth;
  logic          smallDecEnable;
  logic [DW-1:0] smallDecDataOut;
  logic [1:0]    smallCorr;
  logic [1:0]    smallUncorr;
  logic          smallBusy;

  logic [DW-1:0] stubMask;
  logic [1:0]    stubErr;

  int   nChecks;
  int   nErrors;
  int   cycle;
  int   lastAcceptCyc;
  logic prevRespValid;
  exp_t sbQ[$];
  exp_t monEntry;
  int   grantIds[4];
  int   grantCyc[4];
  int   nGrants;
  int   waitCnt;

  // Decoder stub: data is the codeword XOR a programmable mask, error code is programmable.
  assign decDataOut      = decCodeword ^ stubMask;
  assign decErr          = stubErr;
  assign smallDecDataOut = smallDecCodeword ^ stubMask;

  dec_req_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(req0Valid), .o_req0_ready(req0Ready), .i_req0_codeword(req0Cw), .i_req0_width(req0Width),
    .i_req1_valid(req1Valid), .o_req1_ready(req1Ready), .i_req1_codeword(req1Cw), .i_req1_width(req1Width),
    .o_resp_valid(respValid), .i_resp_ready(respReady), .o_resp_id(respId), .o_resp_data(respData),
    .o_resp_num_of_errors(respErr),
    .o_dec_codeword(decCodeword), .o_dec_codeword_width(decWidth), .o_dec_enable(decEnable),
    .i_dec_num_of_errors(decErr), .i_dec_data_out(decDataOut),
    .i_clr_counters(clrCounters), .o_corr_count(corrCount), .o_uncorr_count(uncorrCount), .o_busy(busy)
  );

  dec_req_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dutSmall (
    .clk(clk), .rst(rst),
    .i_req0_valid(req0Valid), .o_req0_ready(smallReq0Ready), .i_req0_codeword(req0Cw), .i_req0_width(req0Width),
    .i_req1_valid(req1Valid), .o_req1_ready(smallReq1Ready), .i_req1_codeword(req1Cw), .i_req1_width(req1Width),
    .o_resp_valid(smallRespValid), .i_resp_ready(respReady), .o_resp_id(smallRespId), .o_resp_data(smallRespData),
    .o_resp_num_of_errors(smallRespErr),
    .o_dec_codeword(smallDecCodeword), .o_dec_codeword_width(smallDecWidth), .o_dec_enable(smallDecEnable),
    .i_dec_num_of_errors(decErr), .i_dec_data_out(smallDecDataOut),
    .i_clr_counters(clrCounters), .o_corr_count(smallCorr), .o_uncorr_count(smallUncorr), .o_busy(smallBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: push the expected response on every grant, pop it on every response handshake.
  always @(negedge clk) begin
    if (rst) begin
      sbQ.delete();
      prevRespValid = 1'b0;
    end else begin
      checkOutput("ready_exclusive", 64'(req0Ready & req1Ready), 64'd0);
      if (req0Ready | req1Ready) begin
        monEntry.id   = req1Ready;
        monEntry.data = (req1Ready ? req1Cw : req0Cw) ^ stubMask;
        monEntry.err  = stubErr;
        sbQ.push_back(monEntry);
        lastAcceptCyc = cycle;
      end
      if (respValid && !prevRespValid)
        checkOutput("resp_latency", 64'(cycle - lastAcceptCyc), 64'd2);
      if (respValid && respReady) begin
        checkOutput("resp_expected", 64'(sbQ.size() != 0), 64'd1);
        if (sbQ.size() != 0) begin
          monEntry = sbQ.pop_front();
          checkOutput("resp_id", 64'(respId), 64'(monEntry.id));
          checkOutput("resp_data", 64'(respData), 64'(monEntry.data));
          checkOutput("resp_errors", 64'(respErr), 64'(monEntry.err));
        end
      end
      prevRespValid = respValid;
    end
  end

  task automatic waitIdle();
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("idle_timeout", 64'(busy), 64'd0);
  endtask

  // One full transaction from a single requester; optionally clears counters on the result edge.
  task automatic applyStimulus(input logic id, input logic [DW-1:0] cw, input logic [1:0] width,
                               input logic [1:0] err, input logic clrInDecode);
    int cnt;
    @(posedge clk); #1;
    stubErr = err;
    if (id) begin
      req1Valid = 1'b1; req1Cw = cw; req1Width = width;
    end else begin
      req0Valid = 1'b1; req0Cw = cw; req0Width = width;
    end
    cnt = 0;
    @(negedge clk);
    while (!(id ? req1Ready : req0Ready) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("req_ready", 64'(id ? req1Ready : req0Ready), 64'd1);
    @(posedge clk); #1;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    if (clrInDecode) clrCounters = 1'b1;
    @(negedge clk);
    checkOutput("dec_enable", 64'(decEnable), 64'd1);
    checkOutput("dec_codeword", 64'(decCodeword), 64'(cw));
    checkOutput("dec_width", 64'(decWidth), 64'(width));
    checkOutput("busy_decode", 64'(busy), 64'd1);
    @(posedge clk); #1;
    clrCounters = 1'b0;
    @(negedge clk);
    checkOutput("dec_enable_resp", 64'(decEnable), 64'd0);
    waitIdle();
  endtask

  initial begin
    nChecks = 0; nErrors = 0; cycle = 0; lastAcceptCyc = 0; prevRespValid = 1'b0;
    rst = 1'b1; respReady = 1'b1; clrCounters = 1'b0;
    req0Valid = 1'b0; req0Cw = '0; req0Width = 2'b00;
    req1Valid = 1'b0; req1Cw = '0; req1Width = 2'b00;
    stubMask = 32'h0000_00A0; stubErr = 2'd0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_resp_valid", 64'(respValid), 64'd0);
    checkOutput("reset_dec_enable", 64'(decEnable), 64'd0);
    checkOutput("reset_dec_codeword", 64'(decCodeword), 64'd0);
    checkOutput("reset_corr", 64'(corrCount), 64'd0);
    checkOutput("reset_small_corr", 64'(smallCorr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] single requests");
    applyStimulus(1'b0, 32'h0000_00A5, 2'b00, 2'd0, 1'b0);
    checkOutput("single_corr", 64'(corrCount), 64'd0);
    checkOutput("single_uncorr", 64'(uncorrCount), 64'd0);
    applyStimulus(1'b1, 32'h1234_5678, 2'b01, 2'd0, 1'b0);

    $display("[TB] contention");
    @(posedge clk); #1;
    req0Cw = 32'h1111_0000; req0Width = 2'b10; req0Valid = 1'b1;
    req1Cw = 32'h2222_0001; req1Width = 2'b01; req1Valid = 1'b1;
    nGrants = 0; waitCnt = 0;
    while (nGrants < 4 && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
      if (req0Ready | req1Ready) begin
        grantIds[nGrants] = int'(req1Ready);
        grantCyc[nGrants] = cycle;
        nGrants++;
      end
    end
    @(posedge clk); #1;
    req0Valid = 1'b0; req1Valid = 1'b0;
    checkOutput("grant_count", 64'(nGrants), 64'd4);
    for (int i = 0; i < nGrants; i++) begin
      checkOutput("grant_order", 64'(grantIds[i]), 64'(i % 2));
      if (i > 0) checkOutput("grant_spacing", 64'(grantCyc[i] - grantCyc[i-1]), 64'd3);
    end
    waitIdle();

    $display("[TB] backpressure");
    @(posedge clk); #1;
    respReady = 1'b0;
    req0Cw = 32'hBEEF_0000; req0Width = 2'b00; req0Valid = 1'b1;
    req1Cw = 32'h0000_CAFE; req1Width = 2'b00; req1Valid = 1'b1;
    @(negedge clk);
    checkOutput("bp_grant0", 64'(req0Ready), 64'd1);
    @(posedge clk); #1;
    req0Valid = 1'b0;
    waitCnt = 0;
    @(negedge clk);
    while (!respValid && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_resp_valid", 64'(respValid), 64'd1);
      checkOutput("bp_resp_data", 64'(respData), 64'(32'hBEEF_0000 ^ 32'h0000_00A0));
      checkOutput("bp_resp_id", 64'(respId), 64'd0);
      checkOutput("bp_no_ready", 64'(req0Ready | req1Ready), 64'd0);
      checkOutput("bp_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    respReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_idle_next", 64'(busy), 64'd0);
    checkOutput("bp_req1_ready", 64'(req1Ready), 64'd1);
    @(posedge clk); #1;
    req1Valid = 1'b0;
    waitIdle();

    $display("[TB] counters");
    applyStimulus(1'b0, 32'h0000_0001, 2'b00, 2'd1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0002, 2'b11, 2'd1, 1'b0);
    applyStimulus(1'b0, 32'h0000_0003, 2'b01, 2'd2, 1'b0);
    applyStimulus(1'b1, 32'h0000_0004, 2'b10, 2'd0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0005, 2'b11, 2'd3, 1'b0);
    checkOutput("cnt_corr", 64'(corrCount), 64'd2);
    checkOutput("cnt_uncorr", 64'(uncorrCount), 64'd1);
    checkOutput("cnt_small_corr", 64'(smallCorr), 64'd2);
    for (int i = 0; i < 5; i++) applyStimulus(1'(i % 2), 32'h0000_0100 + 32'(i), 2'b00, 2'd1, 1'b0);
    checkOutput("cnt_corr_more", 64'(corrCount), 64'd7);
    checkOutput("cnt_small_sat", 64'(smallCorr), 64'd3);
    checkOutput("cnt_small_uncorr", 64'(smallUncorr), 64'd1);
    applyStimulus(1'b0, 32'h0000_0200, 2'b00, 2'd1, 1'b1);
    checkOutput("clr_corr", 64'(corrCount), 64'd0);
    checkOutput("clr_uncorr", 64'(uncorrCount), 64'd0);
    checkOutput("clr_small_corr", 64'(smallCorr), 64'd0);

    $display("[TB] reset mid-decode");
    applyStimulus(1'b0, 32'h0000_0300, 2'b00, 2'd1, 1'b0);
    checkOutput("pre_rst_corr", 64'(corrCount), 64'd1);
    @(posedge clk); #1;
    stubErr = 2'd2;
    req0Cw = 32'hDEAD_0000; req0Width = 2'b11; req0Valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", 64'(req0Ready), 64'd1);
    @(posedge clk); #1;
    req0Valid = 1'b0;
    checkOutput("rst_in_decode", 64'(decEnable), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_dec_enable", 64'(decEnable), 64'd0);
    checkOutput("rst_dec_codeword", 64'(decCodeword), 64'd0);
    checkOutput("rst_dec_width", 64'(decWidth), 64'd0);
    checkOutput("rst_resp_valid", 64'(respValid), 64'd0);
    checkOutput("rst_corr", 64'(corrCount), 64'd0);
    checkOutput("rst_uncorr", 64'(uncorrCount), 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_no_resp", 64'(respValid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    stubErr = 2'd0;
    req0Cw = 32'h0000_0A0A; req0Width = 2'b00; req0Valid = 1'b1;
    req1Cw = 32'h0000_0B0B; req1Width = 2'b00; req1Valid = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req0_first", 64'(req0Ready), 64'd1);
    checkOutput("post_rst_req1_wait", 64'(req1Ready), 64'd0);
    @(posedge clk); #1;
    req0Valid = 1'b0;
    waitCnt = 0;
    @(negedge clk);
    while (!req1Ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("post_rst_req1_grant", 64'(req1Ready), 64'd1);
    @(posedge clk); #1;
    req1Valid = 1'b0;
    waitIdle();
    checkOutput("post_rst_uncorr", 64'(uncorrCount), 64'd0);
    checkOutput("sb_empty", 64'(sbQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
